// File: rtl/ext_mem_responder.sv
// ext_mem_responder
//   Far end of the MMU external-memory burst bus. Accepts one read or write
//   burst of 1-4 beats into a word-addressed SRAM and answers with one
//   rd_ack/rdat per read beat, or a single wr_ack pulse per write burst.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_mem_ext_rden/wren    read / write burst request (write wins if both)
//   i_mem_ext_paddr        burst start byte address, sampled at acceptance
//   i_mem_ext_burst        beat count 1..4 (0 -> 1, >4 -> 4), sampled at acceptance
//   i_mem_ext_burst_vld    write beat valid while in the write state
//   i_mem_ext_mask         byte enables of the current write beat
//   i_mem_ext_wdat         data of the current write beat
//   o_ext_mmu_rdy          idle, a request may be accepted
//   o_ext_mmu_rd_ack       read beat valid
//   o_ext_mmu_rdat         read beat data, 0 when rd_ack is low
//   o_ext_mmu_wr_ack       one-cycle pulse when a write burst completes
module ext_mem_responder #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_ext_rden,
  input  logic                  i_mem_ext_wren,
  input  logic [ADDR_WIDTH-1:0] i_mem_ext_paddr,
  input  logic [2:0]            i_mem_ext_burst,
  input  logic                  i_mem_ext_burst_vld,
  input  logic [MASK_WIDTH-1:0] i_mem_ext_mask,
  input  logic [DATA_WIDTH-1:0] i_mem_ext_wdat,
  output logic                  o_ext_mmu_rdy,
  output logic                  o_ext_mmu_rd_ack,
  output logic [DATA_WIDTH-1:0] o_ext_mmu_rdat,
  output logic                  o_ext_mmu_wr_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_WAIT,
    S_RD_DATA,
    S_WR_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   base_q;
  logic [2:0]              nbeat_q;
  logic [2:0]              beat_q;
  logic [2:0]              lat_q;
  logic                    last_beat;
  logic                    wr_beat;
  logic                    fetch;
  logic [2:0]              rd_idx;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rdat_p1;
  logic                    vld_p1;
  logic                    paddr_unused;

  // Only the word-index bits of the address reach the SRAM.
  assign paddr_unused = ^{i_mem_ext_paddr[ADDR_WIDTH-1:DEPTH_LOG2+4],
                          i_mem_ext_paddr[3:0]};

  function automatic logic [2:0] sat_burst(input logic [2:0] b);
    if (b == 3'd0)      return 3'd1;
    else if (b > 3'd4)  return 3'd4;
    else                return b;
  endfunction

  assign last_beat = (beat_q == nbeat_q - 3'd1);
  assign wr_beat   = (state_q == S_WR) && i_mem_ext_burst_vld && !rst;
  assign wr_addr   = base_q + DEPTH_LOG2'(beat_q);

  // The SRAM read is issued one cycle ahead so the registered beat k is on
  // the bus during the k-th RD_DATA cycle: the first fetch happens on the
  // RD_WAIT -> RD_DATA edge, later ones prefetch beat_q+1.
  assign fetch   = (state_d == S_RD_DATA);
  assign rd_idx  = (state_q == S_RD_DATA) ? beat_q + 3'd1 : 3'd0;
  assign rd_addr = base_q + DEPTH_LOG2'(rd_idx);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_mem_ext_wren)       state_d = S_WR;
        else if (i_mem_ext_rden)  state_d = S_RD_WAIT;
      end
      S_WR: begin
        if (i_mem_ext_burst_vld && last_beat) state_d = S_WR_RESP;
      end
      S_WR_RESP: state_d = S_IDLE;
      S_RD_WAIT: begin
        if (lat_q == 3'(RD_LAT - 1)) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 3'd0;
      lat_q   <= 3'd0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= fetch;
      case (state_q)
        S_IDLE: begin
          beat_q <= 3'd0;
          lat_q  <= 3'd0;
        end
        S_WR:      if (i_mem_ext_burst_vld) beat_q <= beat_q + 3'd1;
        S_RD_WAIT: lat_q  <= lat_q + 3'd1;
        S_RD_DATA: beat_q <= beat_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Burst parameters are captured on the accepting IDLE cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && (i_mem_ext_rden || i_mem_ext_wren)) begin
      base_q  <= i_mem_ext_paddr[DEPTH_LOG2+3:4];
      nbeat_q <= sat_burst(i_mem_ext_burst);
    end
  end

  // Stage p0 -> p1: SRAM write port and registered read data.
  always_ff @(posedge clk) begin
    if (wr_beat) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (i_mem_ext_mask[i]) mem[wr_addr][i*8 +: 8] <= i_mem_ext_wdat[i*8 +: 8];
      end
    end
    if (fetch) rdat_p1 <= mem[rd_addr];
  end

  // Stage p1 outputs: data is gated by its valid so it never needs a reset.
  assign o_ext_mmu_rdy    = (state_q == S_IDLE) && !rst;
  assign o_ext_mmu_rd_ack = vld_p1 && !rst;
  assign o_ext_mmu_rdat   = o_ext_mmu_rd_ack ? rdat_p1 : '0;
  assign o_ext_mmu_wr_ack = (state_q == S_WR_RESP) && !rst;

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder
//   Directed scenarios plus randomized bursts checked against a byte-level
//   memory model of the responder.
module tb_ext_mem_responder;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         rden, wren, bvld;
  logic [33:0]  paddr;
  logic [2:0]   blen;
  logic [15:0]  mask;
  logic [127:0] wdat;
  logic         rdy, rd_ack, wr_ack;
  logic [127:0] rdat;

  int checks   = 0;
  int failures = 0;

  logic [127:0] ref_mem [DEPTH];
  logic [15:0]  wb      [DEPTH];
  logic [127:0] wd [4];
  logic [15:0]  wm [4];

  always #5 clk = ~clk;

  ext_mem_responder #(
    .ADDR_WIDTH(34), .DATA_WIDTH(128), .MASK_WIDTH(16),
    .DEPTH_LOG2(12), .RD_LAT(RD_LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_mem_ext_rden      (rden),
    .i_mem_ext_wren      (wren),
    .i_mem_ext_paddr     (paddr),
    .i_mem_ext_burst     (blen),
    .i_mem_ext_burst_vld (bvld),
    .i_mem_ext_mask      (mask),
    .i_mem_ext_wdat      (wdat),
    .o_ext_mmu_rdy       (rdy),
    .o_ext_mmu_rd_ack    (rd_ack),
    .o_ext_mmu_rdat      (rdat),
    .o_ext_mmu_wr_ack    (wr_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [33:0] rand34();
    return {2'($urandom()), $urandom()};
  endfunction

  function automatic int beats(input logic [2:0] b);
    if (b == 3'd0) return 1;
    if (b > 3'd4) return 4;
    return int'(b);
  endfunction

  task automatic wait_rdy();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (rdy !== 1'b1) chk("rdy_timeout", 128'(rdy), 128'(1));
  endtask

  // Starts in the cycle after read acceptance (cycle +1).
  task automatic read_check(input int base, input int nb);
    for (int c = 1; c <= RD_LAT + nb + 1; c++) begin
      logic         exp_ack;
      int           w;
      logic [127:0] km;
      exp_ack = (c >= RD_LAT + 1) && (c <= RD_LAT + nb);
      w = (base + c - RD_LAT - 1) & (DEPTH - 1);
      chk("rd_ack", 128'(rd_ack), 128'(exp_ack));
      if (!exp_ack) begin
        chk("rdat_idle", rdat, 128'(0));
      end else begin
        for (int i = 0; i < 16; i++) km[i*8 +: 8] = {8{wb[w][i]}};
        if (wb[w] != 16'h0) chk("rdat", rdat & km, ref_mem[w] & km);
      end
      chk("rd_rdy", 128'(rdy), 128'(c == RD_LAT + nb + 1));
      chk("rd_no_wr_ack", 128'(wr_ack), 128'(0));
      if (c < RD_LAT + nb + 1) begin
        // Requests while busy must be ignored, never queued.
        wren = (c + 1 <= RD_LAT + nb) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
    end
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [33:0] addr, input logic [2:0] b);
    int nb, base;
    nb = beats(b);
    base = int'(addr[15:4]);
    wait_rdy();
    rden = 1'b1; paddr = addr; blen = b;
    step();
    rden = 1'b0; paddr = rand34(); blen = 3'($urandom());
    read_check(base, nb);
  endtask

  // stall < 0: random 0..2 idle cycles before each beat; else fixed stalls between beats.
  task automatic do_write(input logic [33:0] addr, input logic [2:0] b, input int stall);
    int nb, base, ns, w;
    nb = beats(b);
    base = int'(addr[15:4]);
    wait_rdy();
    wren = 1'b1; paddr = addr; blen = b;
    step();
    wren = 1'b0; paddr = rand34(); blen = 3'($urandom());
    chk("wr_busy_rdy", 128'(rdy), 128'(0));
    for (int k = 0; k < nb; k++) begin
      ns = (stall < 0) ? $urandom_range(0, 2) : ((k == 0) ? 0 : stall);
      for (int s = 0; s < ns; s++) begin
        bvld = 1'b0; wdat = rand128(); mask = 16'hFFFF;
        step();
        chk("wr_ack_stall", 128'(wr_ack), 128'(0));
      end
      bvld = 1'b1; wdat = wd[k]; mask = wm[k];
      w = (base + k) % DEPTH;
      for (int i = 0; i < 16; i++) begin
        if (wm[k][i]) begin
          ref_mem[w][i*8 +: 8] = wd[k][i*8 +: 8];
          wb[w][i] = 1'b1;
        end
      end
      step();
      if (k < nb - 1) chk("wr_ack_early", 128'(wr_ack), 128'(0));
    end
    bvld = 1'b0; wdat = rand128();
    chk("wr_ack", 128'(wr_ack), 128'(1));
    chk("wr_resp_rdy", 128'(rdy), 128'(0));
    step();
    chk("wr_ack_pulse", 128'(wr_ack), 128'(0));
    chk("wr_done_rdy", 128'(rdy), 128'(1));
  endtask

  task automatic fill_data(input logic full);
    for (int k = 0; k < 4; k++) begin
      wd[k] = rand128();
      wm[k] = (full || $urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom());
    end
  endtask

  initial begin
    logic [11:0] pool [4];
    logic [11:0] word;
    logic [33:0] a;

    for (int i = 0; i < DEPTH; i++) wb[i] = 16'h0;
    rst = 1'b1; rden = 1'b0; wren = 1'b0; bvld = 1'b0;
    paddr = '0; blen = '0; mask = '0; wdat = '0;

    // T1 reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rdy", 128'(rdy), 128'(0));
      chk("rst_rd_ack", 128'(rd_ack), 128'(0));
      chk("rst_wr_ack", 128'(wr_ack), 128'(0));
      chk("rst_rdat", rdat, 128'(0));
    end
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 128'(rdy), 128'(1));

    // T2 four-beat write then read
    for (int k = 0; k < 4; k++) begin
      wd[k] = {4{24'hA0A0A0, 8'(k)}};
      wm[k] = 16'hFFFF;
    end
    do_write(34'h1000, 3'd4, 0);
    do_read(34'h1000, 3'd4);

    // T3 partial mask
    wd[0] = {128{1'b1}}; wm[0] = 16'hFFFF;
    do_write(34'h2000, 3'd1, 0);
    wd[0] = '0; wm[0] = 16'h00F0;
    do_write(34'h2000, 3'd1, 0);
    do_read(34'h2000, 3'd1);

    // T4 address wrap
    fill_data(1'b1);
    do_write(34'hFFE0, 3'd3, 0);
    do_read(34'h0, 3'd1);
    do_read(34'hFFE0, 3'd3);

    // T5 simultaneous read+write: write first, pending read after
    wait_rdy();
    wren = 1'b1; rden = 1'b1; paddr = 34'h3000; blen = 3'd0;
    step();
    wren = 1'b0;
    chk("t5_wr_taken_rdy", 128'(rdy), 128'(0));
    wd[0] = rand128();
    bvld = 1'b1; wdat = wd[0]; mask = 16'hFFFF;
    ref_mem[12'h300] = wd[0]; wb[12'h300] = 16'hFFFF;
    step();
    bvld = 1'b0;
    chk("t5_wr_ack", 128'(wr_ack), 128'(1));
    step();
    chk("t5_wr_ack_pulse", 128'(wr_ack), 128'(0));
    chk("t5_pending_rdy", 128'(rdy), 128'(1));
    step();
    rden = 1'b0;
    read_check(12'h300, 1);

    // burst=7 saturates to four beats
    fill_data(1'b1);
    do_write(34'h2_0000_5000, 3'd7, 0);
    do_read(34'h5000, 3'd7);

    // T6 stalled write, then read aborted by reset after the 2nd beat
    fill_data(1'b1);
    do_write(34'h6000, 3'd4, 2);
    do_read(34'h6000, 3'd4);
    wait_rdy();
    rden = 1'b1; paddr = 34'h6000; blen = 3'd4;
    step();
    rden = 1'b0;
    for (int c = 1; c <= RD_LAT + 2; c++) begin
      chk("abort_rd_ack", 128'(rd_ack), 128'(c >= RD_LAT + 1));
      if (c < RD_LAT + 2) step();
    end
    chk("abort_beat1", rdat, ref_mem[12'h601]);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_rst_rd_ack", 128'(rd_ack), 128'(0));
      chk("abort_rst_rdy", 128'(rdy), 128'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_ack", 128'(rd_ack), 128'(0));
      chk("abort_rdy", 128'(rdy), 128'(1));
    end
    do_read(34'h6000, 3'd4);

    // Randomized traffic around a few hot regions, including the top word
    pool[0] = 12'hFFD; pool[1] = 12'h100; pool[2] = 12'h7FE; pool[3] = 12'h400;
    for (int t = 0; t < 80; t++) begin
      word = pool[$urandom_range(0, 3)] + 12'($urandom_range(0, 6));
      a = {18'($urandom()), word, 4'($urandom())};
      if ($urandom_range(0, 1) == 0) begin
        fill_data(1'b0);
        do_write(a, 3'($urandom()), -1);
      end else begin
        do_read(a, 3'($urandom()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
